// File: rtl/dot_vec_loader.sv
// dot_vec_loader: gathers a stream of signed element pairs into k-wide A/B
// vectors for the dot-product unit. Two banks are used so that one bank can
// fill while the other is presented to the consumer and held until accepted.
module dot_vec_loader #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int cnt_width = $clog2(k)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_clear,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic signed [bit_width-1:0]        i_elem_a,
  input  logic signed [bit_width-1:0]        i_elem_b,
  output logic        [k-1:0][bit_width-1:0] o_vec_a,
  output logic        [k-1:0][bit_width-1:0] o_vec_b,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic        [cnt_width-1:0]        o_fill
);

  localparam logic [cnt_width-1:0] last_idx = cnt_width'(k - 1);

  // bank[n][i] holds element i of the vector stored in bank n
  logic [1:0][k-1:0][bit_width-1:0] bank_a;
  logic [1:0][k-1:0][bit_width-1:0] bank_b;
  logic [1:0]                       full;
  logic                             wr_ptr;
  logic                             rd_ptr;
  logic [cnt_width-1:0]             idx;

  logic accept;
  logic handshake;
  logic complete;

  // Outputs depend only on registered state, so o_ready never waits on
  // i_ready combinationally; a full pair of banks stalls until the drain lands.
  assign o_ready   = ~full[wr_ptr];
  assign o_valid   = full[rd_ptr];
  assign o_vec_a   = bank_a[rd_ptr];
  assign o_vec_b   = bank_b[rd_ptr];
  assign o_fill    = idx;

  // i_clear wins over acceptance; the drain side is unaffected by it
  assign accept    = i_valid & o_ready & ~i_clear;
  assign handshake = o_valid & i_ready;
  assign complete  = accept && (idx == last_idx);

  // Control: fill index, bank pointers and per-bank full flags. A fill
  // completion and a drain can coincide; they always target different banks
  // because accepting needs an empty bank and draining needs a full one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= '0;
    end else begin
      if (i_clear) begin
        idx <= '0;
      end else if (accept) begin
        idx <= complete ? '0 : idx + 1'b1;
      end
      if (complete) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (handshake) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  // Storage: accepted elements are written unmodified into the filling bank;
  // reset clears everything so no stale operands are ever presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_a <= '0;
      bank_b <= '0;
    end else if (accept) begin
      bank_a[wr_ptr][idx] <= i_elem_a;
      bank_b[wr_ptr][idx] <= i_elem_b;
    end
  end

endmodule

// File: tb/tb_dot_vec_loader.sv
// Testbench for dot_vec_loader with k=4, bit_width=8. Sent elements are
// assembled by a small model into expected vector pairs on a queue; a
// monitor pops and compares on every consumer handshake.
module tb_dot_vec_loader;

  localparam int BW = 8;
  localparam int K  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [K*BW-1:0] a;
    logic [K*BW-1:0] b;
  } pair_t;

  logic                        i_clk;
  logic                        i_rst_n;
  logic                        i_clear;
  logic                        i_valid;
  logic                        o_ready;
  logic signed [BW-1:0]        i_elem_a;
  logic signed [BW-1:0]        i_elem_b;
  logic        [K-1:0][BW-1:0] o_vec_a;
  logic        [K-1:0][BW-1:0] o_vec_b;
  logic                        o_valid;
  logic                        i_ready;
  logic        [CW-1:0]        o_fill;

  int total     = 0;
  int bad       = 0;
  int delivered = 0;

  pair_t                 sb_q[$];
  pair_t                 exp_p;
  logic [K-1:0][BW-1:0]  mdl_a;
  logic [K-1:0][BW-1:0]  mdl_b;
  int                    mcnt = 0;

  dot_vec_loader #(.bit_width(BW), .k(K), .cnt_width(CW)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (i_clear),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_elem_a (i_elem_a),
    .i_elem_b (i_elem_b),
    .o_vec_a  (o_vec_a),
    .o_vec_b  (o_vec_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_fill   (o_fill)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // scoreboard monitor: every handshake must deliver the oldest expected pair
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_vec: got a=%h b=%h, none expected", o_vec_a, o_vec_b);
      end else begin
        exp_p = sb_q.pop_front();
        delivered++;
        if (o_vec_a !== exp_p.a || o_vec_b !== exp_p.b) begin
          bad++;
          $display("FAIL vec_pair: got a=%h b=%h, want a=%h b=%h",
                   o_vec_a, o_vec_b, exp_p.a, exp_p.b);
        end
      end
    end
  end

  task automatic model_add(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b);
    pair_t p;
    mdl_a[mcnt] = a;
    mdl_b[mcnt] = b;
    mcnt++;
    if (mcnt == K) begin
      p.a = mdl_a;
      p.b = mdl_b;
      sb_q.push_back(p);
      mcnt = 0;
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b);
    int w;
    w = 0;
    while (o_ready !== 1'b1 && w < 20) begin
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      w++;
    end
    if (w >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: o_ready=%b, want 1 within 20 cycles", o_ready);
    end
    i_valid  = 1'b1;
    i_elem_a = a;
    i_elem_b = b;
    @(posedge i_clk); #1;
    i_valid  = 1'b0;
    model_add(a, b);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #2;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    total++; if (o_fill !== 2'd0) begin bad++; $display("FAIL rst_fill: got %0d want 0", o_fill); end
    total++; if (o_vec_a !== '0 || o_vec_b !== '0) begin
      bad++; $display("FAIL rst_vec: got a=%h b=%h want 0", o_vec_a, o_vec_b);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    send(8'sd1, 8'sd5);
    total++; if (o_fill !== 2'd1) begin bad++; $display("FAIL basic_fill1: got %0d want 1", o_fill); end
    send(-8'sd2, 8'sd6);
    send(8'sd3, -8'sd7);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", o_valid); end
    send(-8'sd4, 8'sd8);
    @(negedge i_clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", o_valid); end
    total++; if (o_vec_a !== 32'hFC03FE01 || o_vec_b !== 32'h08F90605) begin
      bad++; $display("FAIL basic_vec: got a=%h b=%h want a=fc03fe01 b=08f90605", o_vec_a, o_vec_b);
    end
    @(negedge i_clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got %b want 0", o_valid); end
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'(10 * i - 35), 8'(40 - 9 * i));
    end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", o_ready); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", o_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      total++; if (o_valid !== 1'b1 || o_vec_a !== sb_q[0].a || o_vec_b !== sb_q[0].b) begin
        bad++; $display("FAIL bp_hold: got v=%b a=%h b=%h want v=1 a=%h b=%h",
                        o_valid, o_vec_a, o_vec_b, sb_q[0].a, sb_q[0].b);
      end
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", o_ready); end
    total++; if (o_valid !== 1'b1 || o_vec_a !== sb_q[0].a) begin
      bad++; $display("FAIL bp_second: got v=%b a=%h want v=1 a=%h", o_valid, o_vec_a, sb_q[0].a);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", o_valid); end
  endtask

  task automatic test_stream();
    int d0;
    int drops;
    logic signed [BW-1:0] va;
    logic signed [BW-1:0] vb;
    d0    = delivered;
    drops = 0;
    for (int c = 1; c <= 24; c++) begin
      i_ready = (c % 4 == 0);
      if (c <= 20) begin
        if (o_ready !== 1'b1) drops++;
        va = 8'(c * 3 - 30);
        vb = 8'(100 - c * 7);
        i_valid  = 1'b1;
        i_elem_a = va;
        i_elem_b = vb;
        model_add(va, vb);
      end else begin
        i_valid = 1'b0;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    total++; if (drops != 0) begin bad++; $display("FAIL stream_ready_drop: got %0d drops want 0", drops); end
    total++; if (delivered - d0 != 5) begin
      bad++; $display("FAIL stream_count: got %0d vectors want 5", delivered - d0);
    end
  endtask

  task automatic test_clear();
    i_ready = 1'b1;
    send(8'sd7, 8'sd8);
    send(8'sd9, 8'sd10);
    total++; if (o_fill !== 2'd2) begin bad++; $display("FAIL clr_fill_before: got %0d want 2", o_fill); end
    i_clear  = 1'b1;
    i_valid  = 1'b1;
    i_elem_a = 8'sd99;
    i_elem_b = 8'sd99;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    mcnt    = 0;
    total++; if (o_fill !== 2'd0) begin bad++; $display("FAIL clr_fill_after: got %0d want 0", o_fill); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL clr_valid: got %b want 0", o_valid); end
    send(8'sd1, -8'sd1);
    send(8'sd2, -8'sd2);
    send(8'sd3, -8'sd3);
    send(8'sd4, -8'sd4);
    @(negedge i_clk);
    total++; if (o_valid !== 1'b1 || o_vec_a !== 32'h04030201 || o_vec_b !== 32'hFCFDFEFF) begin
      bad++; $display("FAIL clr_vec: got v=%b a=%h b=%h want v=1 a=04030201 b=fcfdfeff",
                      o_valid, o_vec_a, o_vec_b);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(i + 20), 8'(i - 60));
    total++; if (o_valid !== 1'b1 || o_fill !== 2'd2) begin
      bad++; $display("FAIL mid_state: got v=%b fill=%0d want v=1 fill=2", o_valid, o_fill);
    end
    i_rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", o_ready); end
    total++; if (o_fill !== 2'd0) begin bad++; $display("FAIL mid_rst_fill: got %0d want 0", o_fill); end
    sb_q.delete();
    mcnt = 0;
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send(-8'sd5, 8'sd11);
    send(8'sd6, 8'sd12);
    send(-8'sd7, 8'sd13);
    send(8'sd8, 8'sd14);
    @(negedge i_clk);
    total++; if (o_valid !== 1'b1 || o_vec_a !== 32'h08F906FB || o_vec_b !== 32'h0E0D0C0B) begin
      bad++; $display("FAIL mid_next_vec: got v=%b a=%h b=%h want v=1 a=08f906fb b=0e0d0c0b",
                      o_valid, o_vec_a, o_vec_b);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_extreme();
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(-8'sd128, 8'sd127);
    @(negedge i_clk);
    total++; if (o_vec_a !== 32'h80808080 || o_vec_b !== 32'h7F7F7F7F) begin
      bad++; $display("FAIL ext_min_max: got a=%h b=%h want a=80808080 b=7f7f7f7f", o_vec_a, o_vec_b);
    end
    @(posedge i_clk); #1;
    for (int i = 0; i < 4; i++) send(8'sd127, -8'sd128);
    @(negedge i_clk);
    total++; if (o_vec_a !== 32'h7F7F7F7F || o_vec_b !== 32'h80808080) begin
      bad++; $display("FAIL ext_max_min: got a=%h b=%h want a=7f7f7f7f b=80808080", o_vec_a, o_vec_b);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_clear  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_elem_a = '0;
    i_elem_b = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_clear();
    test_reset_mid();
    test_extreme();
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
